bit_serial_adder: RTL

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder_pkg.sv | 16 +
 rtl/FullAdder.sv | 13 +
 rtl/bit_serial_adder.sv | 105 ++++++++++
 3 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the width of the shift-cycle counter.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must be able to represent DATA_WIDTH itself, hence width+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder used for the per-cycle addition in the serial datapath.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: accepts two operands plus carry-in, adds them one bit per
// cycle through a single full adder and presents a registered sum/carry.
//
// state | meaning
// IDLE  | ready for operands (in_rd=1)
// SHIFT | one operand bit added per cycle, DATA_WIDTH cycles
// DONE  | result valid on s/co, waiting for out_rd
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  ci,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  co,
  output logic                  out_vld,
  input  logic                  out_rd
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   a_sr;
  logic [DATA_WIDTH-1:0]   b_sr;
  logic [DATA_WIDTH-1:0]   s_sr;
  logic [DATA_WIDTH-1:0]   sum_next;
  logic                    carry;
  logic [CW-1:0]           cnt;
  logic                    fa_s;
  logic                    fa_co;

  FullAdder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .co (fa_co),
    .s  (fa_s)
  );

  // New sum bit enters at the MSB; after DATA_WIDTH shifts the LSB holds bit 0.
  assign sum_next = DATA_WIDTH'({fa_s, s_sr} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      s       <= '0;
      co      <= 1'b0;
      in_rd   <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= ci;
            cnt   <= '0;
            in_rd <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= sum_next;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            // s/co are separate from the working registers so a finished
            // result survives until the next one completes.
            s       <= sum_next;
            co      <= fa_co;
            out_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_rd) begin
            out_vld <= 1'b0;
            in_rd   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          out_vld <= 1'b0;
          in_rd   <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
